complex_avg_pow2: RTL and testbench

// - Averages fixed windows of 2^LOG2_N complex int16 samples into one complex int16 result.
// - Sits directly upstream of the complex-invert stage.
// - Smooths pilot / channel-estimate samples before they are inverted.
// - AXI-Stream in and out; one output beat per completed window.

---
 rtl/complex_avg_pow2.sv | 136 +++++++++++++
 tb/tb_complex_avg_pow2.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_avg_pow2.sv
// complex_avg_pow2: averages windows of 2^LOG2_N complex int16 samples
// (I in [31:16], Q in [15:0]) into one complex int16 result per window.
// AXI-Stream in and out; the input stalls while a result waits for o_tready.
// Optional macro COMPLEX_AVG_POW2_ROUND_EN: add half an LSB of the result
// before the shift (round half toward +inf) instead of plain flooring.
module complex_avg_pow2 #(
   parameter int LOG2_N = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [31:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready
);

   // Accumulator holds the full sum of a window without overflow.
   localparam int ACC_W = 16 + LOG2_N;
   // One spare count bit keeps the counter legal when LOG2_N is 0.
   localparam int CNT_W = LOG2_N + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

   typedef enum logic {
      ST_ACCUM  = 1'b0,
      ST_OUTPUT = 1'b1
   } state_t;

   state_t                   r_state;
   logic signed [ACC_W-1:0]  r_acc_i;
   logic signed [ACC_W-1:0]  r_acc_q;
   logic [CNT_W-1:0]         r_count;
   logic                     r_last_seen;
   logic [31:0]              r_tdata;
   logic                     r_tlast;
   logic                     r_tvalid;

   logic signed [15:0]       w_samp_i;
   logic signed [15:0]       w_samp_q;
   logic signed [ACC_W-1:0]  w_sum_i;
   logic signed [ACC_W-1:0]  w_sum_q;
   logic signed [ACC_W-1:0]  w_pre_i;
   logic signed [ACC_W-1:0]  w_pre_q;
   logic [15:0]              w_res_i;
   logic [15:0]              w_res_q;
   logic                     w_accept;

   assign w_samp_i = i_tdata[31:16];
   assign w_samp_q = i_tdata[15:0];

   // Sums including the current beat, so the last beat of a window can be
   // folded into the result in the same cycle it is accepted.
   assign w_sum_i = r_acc_i + ACC_W'(w_samp_i);
   assign w_sum_q = r_acc_q + ACC_W'(w_samp_q);

`ifdef COMPLEX_AVG_POW2_ROUND_EN
   // Half of the divisor; evaluates to zero for LOG2_N = 0.
   localparam logic signed [ACC_W-1:0] RND = ACC_W'((1 << LOG2_N) >> 1);
   assign w_pre_i = w_sum_i + RND;
   assign w_pre_q = w_sum_q + RND;
`else
   assign w_pre_i = w_sum_i;
   assign w_pre_q = w_sum_q;
`endif

   // The mean of int16 samples always fits int16, so dropping the upper
   // bits after the arithmetic shift never wraps.
   assign w_res_i = 16'(w_pre_i >>> LOG2_N);
   assign w_res_q = 16'(w_pre_q >>> LOG2_N);

   assign i_tready = (r_state == ST_ACCUM);
   assign w_accept = i_tvalid && (r_state == ST_ACCUM);

   assign o_tdata  = r_tdata;
   assign o_tlast  = r_tlast;
   assign o_tvalid = r_tvalid;

   // Window accumulation, result capture and output handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_ACCUM;
         r_acc_i     <= '0;
         r_acc_q     <= '0;
         r_count     <= '0;
         r_last_seen <= 1'b0;
         r_tdata     <= '0;
         r_tlast     <= 1'b0;
         r_tvalid    <= 1'b0;
      end else if (clear) begin
         // Flush wins over everything, including a beat offered this cycle.
         r_state     <= ST_ACCUM;
         r_acc_i     <= '0;
         r_acc_q     <= '0;
         r_count     <= '0;
         r_last_seen <= 1'b0;
         r_tvalid    <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  if (r_count == CNT_LAST) begin
                     r_tdata     <= {w_res_i, w_res_q};
                     r_tlast     <= r_last_seen | i_tlast;
                     r_tvalid    <= 1'b1;
                     r_acc_i     <= '0;
                     r_acc_q     <= '0;
                     r_count     <= '0;
                     r_last_seen <= 1'b0;
                     r_state     <= ST_OUTPUT;
                  end else begin
                     r_acc_i     <= w_sum_i;
                     r_acc_q     <= w_sum_q;
                     r_count     <= r_count + 1'b1;
                     r_last_seen <= r_last_seen | i_tlast;
                  end
               end
            end
            ST_OUTPUT: begin
               if (o_tready) begin
                  r_tvalid <= 1'b0;
                  r_state  <= ST_ACCUM;
               end
            end
            default: begin
               r_state  <= ST_ACCUM;
               r_tvalid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_complex_avg_pow2.sv
// Testbench for complex_avg_pow2 with LOG2_N = 2 (windows of 4 samples).
// A window-level model (sum the accepted samples, divide, hold until taken)
// is compared with the DUT every cycle; directed tests pin literal results.
module tb_complex_avg_pow2;

   localparam int LOG2_N = 2;
   localparam int N      = 4;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        clear    = 1'b0;
   logic [31:0] i_tdata  = '0;
   logic        i_tlast  = 1'b0;
   logic        i_tvalid = 1'b0;
   logic        o_tready = 1'b1;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;

   int checks = 0;
   int errors = 0;

   complex_avg_pow2 #(.LOG2_N(LOG2_N)) dut (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .i_tvalid (i_tvalid),
      .i_tready (i_tready),
      .o_tdata  (o_tdata),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Mean of N samples: floor(sum/N), or floor((sum + N/2)/N) when rounding.
   function automatic logic [15:0] window_mean(input int sum);
      int s;
      int q;
      s = sum;
`ifdef COMPLEX_AVG_POW2_ROUND_EN
      s = s + N / 2;
`endif
      if (s >= 0) q = s / N;
      else        q = -((-s + N - 1) / N);
      return 16'(q);
   endfunction

   int          m_sum_i = 0;
   int          m_sum_q = 0;
   int          m_n     = 0;
   bit          m_seen  = 1'b0;
   bit          m_valid = 1'b0;
   logic [31:0] m_data  = '0;
   bit          m_last  = 1'b0;

   always @(posedge clk or posedge reset) begin
      int si;
      int sq;
      if (reset) begin
         m_sum_i <= 0; m_sum_q <= 0; m_n <= 0; m_seen <= 1'b0;
         m_valid <= 1'b0; m_data <= '0; m_last <= 1'b0;
      end else if (clear) begin
         m_sum_i <= 0; m_sum_q <= 0; m_n <= 0; m_seen <= 1'b0;
         m_valid <= 1'b0;
      end else if (m_valid) begin
         if (o_tready) m_valid <= 1'b0;
      end else if (i_tvalid) begin
         si = m_sum_i + int'($signed(i_tdata[31:16]));
         sq = m_sum_q + int'($signed(i_tdata[15:0]));
         if (m_n == N - 1) begin
            m_data  <= {window_mean(si), window_mean(sq)};
            m_last  <= m_seen | i_tlast;
            m_valid <= 1'b1;
            m_sum_i <= 0; m_sum_q <= 0; m_n <= 0; m_seen <= 1'b0;
         end else begin
            m_sum_i <= si; m_sum_q <= sq; m_n <= m_n + 1;
            m_seen  <= m_seen | i_tlast;
         end
      end
   end

   // Cycle-by-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (!reset) begin
         checks = checks + 1;
         if (o_tvalid !== m_valid || i_tready !== !m_valid || o_tdata !== m_data
             || o_tlast !== m_last) begin
            errors = errors + 1;
            $display("FAIL cycle_model t=%0t: got valid=%b ready=%b data=%h last=%b, want valid=%b ready=%b data=%h last=%b",
                     $time, o_tvalid, i_tready, o_tdata, o_tlast, m_valid, !m_valid, m_data, m_last);
         end
      end
   end

   // ---------------- output capture ----------------
   int         dut_acc = 0;
   logic [32:0] obs_q[$];
   int          obs_acc_q[$];

   always @(posedge clk) begin
      if (!reset && !clear) begin
         if (i_tvalid && i_tready) dut_acc <= dut_acc + 1;
         if (o_tvalid && o_tready) begin
            obs_q.push_back({o_tlast, o_tdata});
            obs_acc_q.push_back(dut_acc);
            $display("out: tlast=%b tdata=%h (beats accepted so far %0d)", o_tlast, o_tdata, dut_acc);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Offer one beat starting at a falling edge; return at the falling edge
   // after it was accepted.
   task automatic send(input logic [15:0] iv, input logic [15:0] qv, input logic last);
      bit ok;
      ok = 1'b0;
      i_tdata  = {iv, qv};
      i_tlast  = last;
      i_tvalid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         ok = i_tready;
         @(posedge clk);
         @(negedge clk);
      end
      if (!ok) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL send_timeout: got not accepted, want accepted (%h)", {iv, qv});
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!o_tvalid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_tvalid) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s_timeout: got o_tvalid=0, want 1", name);
      end
   endtask

   task automatic expect_out(input string name, input logic [32:0] exp, output int acc_at);
      int n;
      n = 0;
      acc_at = -1;
      while (obs_q.size() == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (obs_q.size() == 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s_timeout: got no output, want %h", name, exp);
      end else begin
         acc_at = obs_acc_q.pop_front();
         chk(name, obs_q.pop_front(), exp);
      end
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] e1, e4, held;
   int          base, acc_at;

   initial begin
`ifdef COMPLEX_AVG_POW2_ROUND_EN
      e1 = 32'h0003_FFFE;  // (3, -2)
      e4 = 32'h000C_0016;  // (12, 22)
`else
      e1 = 32'h0002_FFFD;  // (2, -3)
      e4 = 32'h000B_0015;  // (11, 21)
`endif
      repeat (2) @(negedge clk);
      chk("reset_tvalid", {32'd0, o_tvalid}, 33'd0);
      chk("reset_tready", {32'd0, i_tready}, 33'd1);
      chk("reset_tdata",  {1'b0, o_tdata},   33'd0);
      chk("reset_tlast",  {32'd0, o_tlast},  33'd0);
      reset = 1'b0;
      @(negedge clk);

      // Ramp window.
      for (int k = 1; k <= 4; k++) send(16'(k), 16'(-k), 1'b0);
      expect_out("ramp", {1'b0, e1}, acc_at);

      // Full-scale extremes.
      repeat (4) send(16'h8000, 16'h7FFF, 1'b0);
      expect_out("fullscale_mix", {1'b0, 32'h8000_7FFF}, acc_at);
      repeat (4) send(16'h8000, 16'h8000, 1'b0);
      expect_out("fullscale_neg", {1'b0, 32'h8000_8000}, acc_at);

      // Backpressure: result held for 10 cycles, fifth beat waits.
      o_tready = 1'b0;
      base = dut_acc;
      fork
         begin
            for (int k = 0; k < 4; k++) send(16'(10 + k), 16'(20 + k), 1'b0);
            repeat (4) send(16'd0, 16'd0, 1'b0);
         end
         begin
            wait_valid("bp");
            held = o_tdata;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               chk($sformatf("bp_hold_data_%0d", k), {1'b0, o_tdata}, {1'b0, held});
               chk($sformatf("bp_hold_ready_%0d", k), {32'd0, i_tready}, 33'd0);
            end
            o_tready = 1'b1;
         end
      join
      expect_out("bp_win1", {1'b0, e4}, acc_at);
      chk("bp_beats_before_hs", 33'(acc_at - base), 33'd4);
      expect_out("bp_win2", {1'b0, 32'h0000_0000}, acc_at);

      // tlast is recorded, never ends a window early.
      send(16'd1, 16'd1, 1'b0);
      send(16'd1, 16'd1, 1'b1);
      send(16'd1, 16'd1, 1'b0);
      send(16'd1, 16'd1, 1'b0);
      repeat (4) send(16'd1, 16'd1, 1'b0);
      expect_out("tlast_win1", {1'b1, 32'h0001_0001}, acc_at);
      expect_out("tlast_win2", {1'b0, 32'h0001_0001}, acc_at);

      // clear after 3 beats, with a beat offered in the clear cycle.
      repeat (3) send(16'd100, 16'd100, 1'b0);
      clear    = 1'b1;
      i_tvalid = 1'b1;
      i_tdata  = {16'd100, 16'd100};
      @(negedge clk);
      clear    = 1'b0;
      i_tvalid = 1'b0;
      repeat (4) send(16'd8, 16'd8, 1'b0);
      expect_out("clear_result", {1'b0, 32'h0008_0008}, acc_at);
      repeat (6) @(negedge clk);
      chk("clear_single_output", 33'(obs_q.size()), 33'd0);

      // Async reset mid-window.
      repeat (2) send(16'd50, 16'd50, 1'b0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("areset_mid_tvalid", {32'd0, o_tvalid}, 33'd0);
      chk("areset_mid_tready", {32'd0, i_tready}, 33'd1);
      @(negedge clk);
      reset = 1'b0;

      // Async reset while a result is pending.
      o_tready = 1'b0;
      repeat (4) send(16'd7, 16'd7, 1'b0);
      wait_valid("areset_out");
      #2 reset = 1'b1;
      #1;
      chk("areset_out_tvalid", {32'd0, o_tvalid}, 33'd0);
      chk("areset_out_tdata",  {1'b0, o_tdata},   33'd0);
      @(negedge clk);
      reset    = 1'b0;
      o_tready = 1'b1;
      repeat (4) send(16'd4, 16'hFFFC, 1'b0);
      expect_out("after_reset", {1'b0, 32'h0004_FFFC}, acc_at);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
